bus_master_arb: RTL

- Master-side front end of the system bus. Arbitrates between M0 (host/testbench, default owner) and M1 (DMA engine).
- Drives the shared slave-facing bus (s_addr, s_wr, s_din) from the granted master. The address decoder downstream consumes s_addr to produce s0_sel/s1_sel.
- Returns slave read data to masters on m_din, aligned to the slaves' 1-cycle synchronous read latency, using registered decoder selects.

---
 rtl/bus_master_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/bus_master_arb.sv
// Two-master bus front end: arbitrates M0 (default owner) against M1 (DMA),
// muxes the granted master onto the slave bus and returns registered-select read data.
module bus_master_arb #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic              s0_sel,
    input  logic              s1_sel,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] m_din
);

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_t;

    // MAX_HOLD of zero turns preemption off entirely; the counter then never moves.
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [1:0]         sel_q;

    // NOTE: every signal is given a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            M0_GRANT: begin
                if (!m0_req && m1_req) begin
                    state_nxt    = M1_GRANT;
                    hold_cnt_nxt = '0;
                end
            end
            M1_GRANT: begin
                if (!m1_req) begin
                    state_nxt = M0_GRANT;
                end else if (PREEMPT_EN && m0_req) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = M0_GRANT;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = M0_GRANT;
        endcase
    end

    // NOTE: reset is sampled on the clock edge here, not asynchronously, so it sits
    // inside the edge-triggered block as an ordinary first branch.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= M0_GRANT;
            hold_cnt <= '0;
            sel_q    <= 2'b00;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            sel_q    <= {s0_sel, s1_sel};
        end
    end

    assign m0_grant = (state == M0_GRANT);
    assign m1_grant = (state == M1_GRANT);

    // The non-granted master's strobe is masked so it can never write the bus.
    always_comb begin
        if (state == M1_GRANT) begin
            s_addr = m1_addr;
            s_din  = m1_dout;
            s_wr   = m1_wr && m1_req;
        end else begin
            s_addr = m0_addr;
            s_din  = m0_dout;
            s_wr   = m0_wr && m0_req;
        end
    end

    // Selects were registered alongside the address, matching the slaves' one-cycle read.
    always_comb begin
        case (sel_q)
            2'b10:   m_din = s0_dout;
            2'b01:   m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule
